// File: rtl/csr_timer_unit_pkg.sv
// Shared CSR addresses, TCFG field positions and the per-channel address decoder
// used by the timer unit.
package csr_timer_unit_pkg;

    localparam logic [13:0] CSR_TID          = 14'h040;
    localparam logic [13:0] CSR_TCFG_BASE    = 14'h041;
    localparam logic [13:0] CSR_TVAL_BASE    = 14'h042;
    localparam logic [13:0] CSR_TICLR_BASE   = 14'h044;
    localparam logic [13:0] CSR_TIMER_STRIDE = 14'd8;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PER      = 1;
    localparam int TCFG_INITV_LO = 2;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TCFG,
        SEL_TVAL,
        SEL_TICLR
    } chan_sel_e;

    function automatic chan_sel_e chan_decode(input logic [13:0] num, input int unsigned idx);
        logic [13:0] off;
        off = 14'(idx) * CSR_TIMER_STRIDE;
        if (num == CSR_TCFG_BASE + off)  return SEL_TCFG;
        if (num == CSR_TVAL_BASE + off)  return SEL_TVAL;
        if (num == CSR_TICLR_BASE + off) return SEL_TICLR;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/csr_timer_unit_if.sv
// CSR access bus between the pipeline EXE/WB stage (master) and the timer unit (slave).
interface csr_timer_unit_if;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    modport master (
        output csr_we, csr_num, csr_wmask, csr_wdata,
        input  csr_rdata, csr_hit
    );

    modport slave (
        input  csr_we, csr_num, csr_wmask, csr_wdata,
        output csr_rdata, csr_hit
    );
endinterface

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG, TVAL and the interrupt-pending flag, with the
// write / clear / expiry priority resolved in a single next-state block.
module csr_timer_chan
    import csr_timer_unit_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tcfg_we,
    input  logic               ticlr_we,
    input  logic [TIMER_W-1:0] wmask,
    input  logic [TIMER_W-1:0] wdata,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               pending
);

    logic [TIMER_W-1:0] tcfg_reg, tcfg_next;
    logic [TIMER_W-1:0] tval_reg, tval_next;
    logic               pending_reg, pending_next;
    logic [TIMER_W-1:0] tcfg_wr;
    logic               expire;

    always_comb begin
        tcfg_wr      = (wmask & wdata) | (~wmask & tcfg_reg);
        expire       = tcfg_reg[TCFG_EN] && (tval_reg == '0);
        tcfg_next    = tcfg_reg;
        tval_next    = tval_reg;
        pending_next = pending_reg;

        if (tcfg_we) begin
            tcfg_next = tcfg_wr;
            tval_next = {tcfg_wr[TIMER_W-1:TCFG_INITV_LO], 2'b00};
        end else if (tcfg_reg[TCFG_EN]) begin
            if (!expire)
                tval_next = tval_reg - TIMER_W'(1);
            else if (tcfg_reg[TCFG_PER])
                tval_next = {tcfg_reg[TIMER_W-1:TCFG_INITV_LO], 2'b00};
            else
                tcfg_next[TCFG_EN] = 1'b0;
        end

        // An expiry on the same edge as a clear keeps the interrupt pending.
        if (expire)
            pending_next = 1'b1;
        else if (ticlr_we && wmask[0] && wdata[0])
            pending_next = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_reg    <= '0;
            tval_reg    <= '0;
            pending_reg <= 1'b0;
        end else begin
            tcfg_reg    <= tcfg_next;
            tval_reg    <= tval_next;
            pending_reg <= pending_next;
        end
    end

    assign tcfg    = tcfg_reg;
    assign tval    = tval_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/csr_timer_unit.sv
// Timer/interrupt-source unit: N_TIMER countdown channels, stable counter, TID and
// interrupt-line synchronisers behind a combinational CSR read port.
module csr_timer_unit
    import csr_timer_unit_pkg::*;
#(
    parameter int N_TIMER     = 2,
    parameter int TIMER_W     = 32,
    parameter int CNT_W       = 64,
    parameter int N_HWI       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    csr_timer_unit_if.slave    bus,
    input  logic [N_HWI-1:0]   hard_int_in,
    input  logic               ipi_int_in,
    output logic [N_HWI-1:0]   hwi_sync,
    output logic               ipi_sync,
    output logic [N_TIMER-1:0] ti_pending,
    output logic [CNT_W-1:0]   stable_cnt,
    output logic [31:0]        counter_id
);

    logic [31:0]      tid_reg;
    logic [CNT_W-1:0] stable_cnt_reg;
    logic [N_HWI:0]   sync_reg [SYNC_STAGES];
    logic             tid_hit;
    logic [31:0]      chan_rdata [N_TIMER];
    logic [N_TIMER-1:0] chan_hit;
    logic [31:0]      rdata_mux;
    logic             hit_mux;

    assign tid_hit = (bus.csr_num == CSR_TID);

    generate
        for (genvar gi = 0; gi < N_TIMER; gi++) begin : g_chan
            chan_sel_e          sel;
            logic [TIMER_W-1:0] tcfg;
            logic [TIMER_W-1:0] tval;

            assign sel = chan_decode(bus.csr_num, gi);

            csr_timer_chan #(.TIMER_W(TIMER_W)) u_chan (
                .clk      (clk),
                .resetn   (resetn),
                .tcfg_we  (bus.csr_we && (sel == SEL_TCFG)),
                .ticlr_we (bus.csr_we && (sel == SEL_TICLR)),
                .wmask    (bus.csr_wmask[TIMER_W-1:0]),
                .wdata    (bus.csr_wdata[TIMER_W-1:0]),
                .tcfg     (tcfg),
                .tval     (tval),
                .pending  (ti_pending[gi])
            );

            // TICLR decodes as a hit but always reads back as zero.
            assign chan_hit[gi]   = (sel != SEL_NONE);
            assign chan_rdata[gi] = (sel == SEL_TCFG) ? 32'(tcfg) :
                                    (sel == SEL_TVAL) ? 32'(tval) : 32'd0;
        end
    endgenerate

    always_comb begin
        rdata_mux = tid_hit ? tid_reg : 32'd0;
        hit_mux   = tid_hit;
        for (int i = 0; i < N_TIMER; i++) begin
            rdata_mux = rdata_mux | chan_rdata[i];
            hit_mux   = hit_mux | chan_hit[i];
        end
    end

    assign bus.csr_rdata = rdata_mux;
    assign bus.csr_hit   = hit_mux;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_reg        <= '0;
            stable_cnt_reg <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_reg[i] <= '0;
        end else begin
            if (bus.csr_we && tid_hit)
                tid_reg <= (bus.csr_wmask & bus.csr_wdata) | (~bus.csr_wmask & tid_reg);
            stable_cnt_reg <= stable_cnt_reg + CNT_W'(1);
            sync_reg[0]    <= {ipi_int_in, hard_int_in};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_reg[i] <= sync_reg[i-1];
        end
    end

    assign hwi_sync   = sync_reg[SYNC_STAGES-1][N_HWI-1:0];
    assign ipi_sync   = sync_reg[SYNC_STAGES-1][N_HWI];
    assign stable_cnt = stable_cnt_reg;
    assign counter_id = tid_reg;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Directed and randomised checks of csr_timer_unit against an arithmetic model that
// derives TVAL/pending from the time elapsed since each TCFG write.
module tb_csr_timer_unit;

    localparam int NT = 2;
    localparam int S  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  hard_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic [7:0]  hwi_sync;
    logic        ipi_sync;
    logic [1:0]  ti_pending;
    logic [63:0] stable_cnt;
    logic [31:0] counter_id;

    csr_timer_unit_if bus();

    csr_timer_unit #(
        .N_TIMER(NT), .TIMER_W(32), .CNT_W(64), .N_HWI(8), .SYNC_STAGES(S)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .hard_int_in (hard_int_in),
        .ipi_int_in  (ipi_int_in),
        .hwi_sync    (hwi_sync),
        .ipi_sync    (ipi_sync),
        .ti_pending  (ti_pending),
        .stable_cnt  (stable_cnt),
        .counter_id  (counter_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: configuration as last written, the edge it was written on,
    // latest expiry of earlier configurations, and latest clear edge.
    longint      cyc;
    logic [31:0] m_cfg  [NT];
    longint      m_w    [NT];
    longint      m_lexp [NT];
    longint      m_lclr [NT];
    logic [31:0] m_tid;
    logic [8:0]  hist [longint];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint per_len(input int ch);
        return 4 * longint'(m_cfg[ch][31:2]) + 1;
    endfunction

    function automatic longint cur_exp(input int ch, input longint e);
        longint p, j;
        if (!m_cfg[ch][0]) return -1;
        p = per_len(ch);
        j = e - m_w[ch];
        if (j < p) return -1;
        if (!m_cfg[ch][1]) return m_w[ch] + p;
        return m_w[ch] + (j / p) * p;
    endfunction

    function automatic logic [31:0] exp_tval(input int ch, input longint e);
        longint p, j;
        p = per_len(ch);
        j = e - m_w[ch];
        if (!m_cfg[ch][0]) return 32'(p - 1);
        if (m_cfg[ch][1]) return 32'((p - 1) - (j % p));
        return (j <= p - 1) ? 32'((p - 1) - j) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_cfg(input int ch, input longint e);
        logic [31:0] r;
        r = m_cfg[ch];
        if (r[0] && !r[1] && (e - m_w[ch]) >= per_len(ch)) r[0] = 1'b0;
        return r;
    endfunction

    function automatic logic exp_pend(input int ch, input longint e);
        longint l;
        l = cur_exp(ch, e);
        if (m_lexp[ch] > l) l = m_lexp[ch];
        return (l >= 0) && (l >= m_lclr[ch]);
    endfunction

    task automatic model_read(input logic [13:0] num, input longint e,
                              output logic hit, output logic [31:0] d);
        logic [13:0] base;
        hit = 1'b0;
        d   = '0;
        if (num == 14'h040) begin hit = 1'b1; d = m_tid; end
        for (int ch = 0; ch < NT; ch++) begin
            base = 14'h041 + 14'(8 * ch);
            if (num == base)          begin hit = 1'b1; d = exp_cfg(ch, e);  end
            if (num == base + 14'd1)  begin hit = 1'b1; d = exp_tval(ch, e); end
            if (num == base + 14'd3)  begin hit = 1'b1; d = '0;              end
        end
    endtask

    task automatic model_write(input logic [13:0] num, input logic [31:0] mask,
                               input logic [31:0] data, input longint e);
        logic [13:0] base;
        longint      l;
        if (num == 14'h040) m_tid = (mask & data) | (~mask & m_tid);
        for (int ch = 0; ch < NT; ch++) begin
            base = 14'h041 + 14'(8 * ch);
            if (num == base) begin
                l = cur_exp(ch, e);
                if (l > m_lexp[ch]) m_lexp[ch] = l;
                m_cfg[ch] = (mask & data) | (~mask & exp_cfg(ch, e - 1));
                m_w[ch]   = e;
            end
            if (num == base + 14'd3 && (mask[0] & data[0])) m_lclr[ch] = e;
        end
    endtask

    task automatic model_reset();
        cyc   = 0;
        m_tid = '0;
        for (int ch = 0; ch < NT; ch++) begin
            m_cfg[ch]  = '0;
            m_w[ch]    = 0;
            m_lexp[ch] = -1;
            m_lclr[ch] = -1;
        end
        hist.delete();
    endtask

    task automatic check_outputs();
        logic [1:0] pend;
        logic [8:0] sv;
        longint     idx;
        for (int ch = 0; ch < NT; ch++) pend[ch] = exp_pend(ch, cyc);
        idx = cyc - S + 1;
        sv  = (idx >= 1 && hist.exists(idx)) ? hist[idx] : 9'd0;
        chk($sformatf("ti_pending@%0d", cyc), 64'(ti_pending), 64'(pend));
        chk($sformatf("stable_cnt@%0d", cyc), stable_cnt, 64'(cyc));
        chk($sformatf("counter_id@%0d", cyc), 64'(counter_id), 64'(m_tid));
        chk($sformatf("hwi_sync@%0d", cyc), 64'(hwi_sync), 64'(sv[7:0]));
        chk($sformatf("ipi_sync@%0d", cyc), 64'(ipi_sync), 64'(sv[8]));
    endtask

    // Entered at a falling edge: drive the bus, check the combinational read of the
    // current state, apply the write on the next rising edge, then check outputs.
    task automatic cyc_op(input logic we, input logic [13:0] num,
                          input logic [31:0] mask, input logic [31:0] data);
        logic        h;
        logic [31:0] d;
        bus.csr_we    = we;
        bus.csr_num   = num;
        bus.csr_wmask = mask;
        bus.csr_wdata = data;
        #1;
        model_read(num, cyc, h, d);
        chk($sformatf("hit[%h]@%0d", num, cyc), 64'(bus.csr_hit), 64'(h));
        chk($sformatf("rdata[%h]@%0d", num, cyc), 64'(bus.csr_rdata), 64'(d));
        if (we) model_write(num, mask, data, cyc + 1);
        hist[cyc + 1] = {ipi_int_in, hard_int_in};
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.csr_we = 1'b0;
        check_outputs();
        $display("cyc %0d we=%0b num=%h rdata=%h pend=%b", cyc, we, num, d, ti_pending);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] addr_tab [10];
        logic [31:0] msk, dat;
        longint      w1;
        int          r, ch;

        addr_tab = '{14'h040, 14'h041, 14'h042, 14'h044, 14'h049,
                     14'h04A, 14'h04C, 14'h043, 14'h051, 14'h045};
        bus.csr_we = 1'b0; bus.csr_num = '0; bus.csr_wmask = '0; bus.csr_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check_outputs();

        // Reset in the middle of a count
        cyc_op(1'b1, 14'h040, 32'hFFFF_FFFF, 32'h1234_5678);
        hard_int_in = 8'hFF; ipi_int_in = 1'b1;
        cyc_op(1'b1, 14'h041, 32'hFFFF_FFFF, 32'h0000_0011);
        cyc_op(1'b1, 14'h049, 32'hFFFF_FFFF, 32'h0000_0003);
        repeat (4) cyc_op(1'b0, 14'h042, '0, '0);
        bus.csr_num = 14'h042;
        #2 resetn = 1'b0;
        #1;
        chk("rst_pending", 64'(ti_pending), 64'd0);
        chk("rst_stable",  stable_cnt, 64'd0);
        chk("rst_tid",     64'(counter_id), 64'd0);
        chk("rst_hwi",     64'(hwi_sync), 64'd0);
        chk("rst_ipi",     64'(ipi_sync), 64'd0);
        chk("rst_tval",    64'(bus.csr_rdata), 64'd0);
        hard_int_in = '0; ipi_int_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check_outputs();
        repeat (3) cyc_op(1'b0, 14'h042, '0, '0);

        // One-shot channel 0, INITV=2
        cyc_op(1'b1, 14'h041, 32'hFFFF_FFFF, 32'h0000_0009);
        repeat (12) cyc_op(1'b0, 14'h042, '0, '0);
        cyc_op(1'b0, 14'h041, '0, '0);

        // Periodic channel 1, period 9; clear off-expiry, then clear on an expiry edge
        cyc_op(1'b1, 14'h049, 32'hFFFF_FFFF, 32'h0000_000B);
        w1 = cyc;
        repeat (10) cyc_op(1'b0, 14'h04A, '0, '0);
        cyc_op(1'b1, 14'h04C, 32'h1, 32'h1);
        while (cyc + 1 < w1 + 18) cyc_op(1'b0, 14'h04A, '0, '0);
        cyc_op(1'b1, 14'h04C, 32'h1, 32'h1);
        chk("ticlr_on_expiry", 64'(ti_pending[1]), 64'd1);
        cyc_op(1'b0, 14'h04C, '0, '0);

        // Masked TCFG write clears EN only
        cyc_op(1'b1, 14'h041, 32'hFFFF_FFFF, 32'h0000_00FF);
        cyc_op(1'b1, 14'h041, 32'h0000_0001, 32'h0);
        repeat (4) cyc_op(1'b0, 14'h042, '0, '0);
        cyc_op(1'b0, 14'h041, '0, '0);

        // Synchroniser pulses
        hard_int_in[3] = 1'b1;
        repeat (3) cyc_op(1'b0, 14'h040, '0, '0);
        hard_int_in[3] = 1'b0;
        repeat (4) cyc_op(1'b0, 14'h040, '0, '0);
        ipi_int_in = 1'b1;
        repeat (3) cyc_op(1'b0, 14'h040, '0, '0);
        ipi_int_in = 1'b0;
        repeat (4) cyc_op(1'b0, 14'h040, '0, '0);

        // Unmapped addresses, TVAL write ignored, TID readback
        cyc_op(1'b0, 14'h043, '0, '0);
        cyc_op(1'b0, 14'h3FF0, '0, '0);
        cyc_op(1'b1, 14'h042, 32'hFFFF_FFFF, 32'h5555_5555);
        cyc_op(1'b1, 14'h040, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        cyc_op(1'b0, 14'h040, '0, '0);

        // Randomised traffic
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 3) == 0) hard_int_in[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) ipi_int_in = ~ipi_int_in;
            r   = $urandom_range(0, 9);
            ch  = $urandom_range(0, NT - 1);
            msk = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            case (r)
                0, 1: begin
                    dat = (32'($urandom_range(0, 6)) << 2) | ($urandom & 32'h3);
                    cyc_op(1'b1, 14'h041 + 14'(8 * ch), msk, dat);
                end
                2: cyc_op(1'b1, 14'h044 + 14'(8 * ch), msk, $urandom);
                3: cyc_op(1'b1, 14'h040, msk, $urandom);
                4: cyc_op(1'b1, 14'h042 + 14'(8 * ch), msk, $urandom);
                default: begin
                    if ($urandom_range(0, 4) == 0)
                        cyc_op(1'b0, 14'($urandom_range(0, 16383)), '0, '0);
                    else
                        cyc_op(1'b0, addr_tab[$urandom_range(0, 9)], '0, '0);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
